// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path:
// controller states, ALU operation codes, immediate selects and opcodes.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRWB,
    S_UPPER, S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate format is a pure function of the opcode, so it is valid in every state.
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         imm_sel = IMM_S;
      OP_BRANCH:        imm_sel = IMM_B;
      OP_JAL:           imm_sel = IMM_J;
      OP_LUI, OP_AUIPC: imm_sel = IMM_U;
      default:          imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv_mc_aludec.sv
// ALU operation decoder: maps the controller's coarse aluop plus the
// instruction function fields onto a concrete ALU operation code.
module rv_mc_aludec
  import rv_mc_pkg::*;
(
  input  aluop_e     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // instr[30] is part of the immediate for addi, so only R-type may subtract
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_mc_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, address generation
// and execute over a shared ALU and a single ready-handshaked memory port.
module rv_mc_controller
  import rv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] immsrc,
  output logic [3:0] alucontrol,
  output logic       illegal
);

  state_e state_q, state_d;
  logic   illegal_q;
  aluop_e aluop;
  logic   br_taken, br_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
    end
  end

  always_comb begin
    br_valid = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    memwrite  = 1'b0;
    adrsrc    = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        adrsrc   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        // Target was computed in DECODE and sits in ALUOut; the ALU now compares.
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        pcwrite = br_valid && br_taken;
        state_d = br_valid ? S_FETCH : S_TRAP;
      end
      S_JAL: begin
        pcwrite = 1'b1;
        alusrca = 2'b01;
        alusrcb = 2'b10;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        alusrca   = 2'b10;
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        pcwrite   = 1'b1;
        state_d   = S_JALRWB;
      end
      S_JALRWB: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        regwrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_UPPER: begin
        alusrca = op[5] ? 2'b11 : 2'b01;
        alusrcb = 2'b01;
        state_d = S_ALUWB;
      end
      default: state_d = S_TRAP;
    endcase
    // Reset kills strobes combinationally so an abort never leaves a partial write.
    if (!reset_n) begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign immsrc  = imm_sel(op);
  assign illegal = illegal_q;

  rv_mc_aludec u_aludec (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_rv_mc_controller.sv
// Randomized bench: each instruction is expanded into its expected cycle-by-cycle
// output sequence from the instruction-class tables, then compared per cycle.
module tb_rv_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;
  logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb;
  logic [2:0] immsrc;
  logic [3:0] alucontrol;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rv_mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .adrsrc(adrsrc), .irwrite(irwrite),
    .pcwrite(pcwrite), .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .immsrc(immsrc), .alucontrol(alucontrol), .illegal(illegal)
  );

  // Output vector: mem_req memwrite adrsrc irwrite pcwrite regwrite rs[2] sa[2] sb[2] alu[4] imm[3] illegal
  logic [19:0] obs;
  assign obs = {mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, resultsrc,
                alusrca, alusrcb, alucontrol, immsrc, illegal};

  localparam logic [19:0] M_STB = 20'hDC001;
  localparam logic [19:0] M_ADR = 20'h20000;
  localparam logic [19:0] M_RS  = 20'h03000;
  localparam logic [19:0] M_SA  = 20'h00C00;
  localparam logic [19:0] M_SB  = 20'h00300;
  localparam logic [19:0] M_ALU = 20'h000F0;
  localparam logic [19:0] M_IMM = 20'h0000E;

  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, RTYPE = 7'h33, ITYPE = 7'h13,
                         BRANCH = 7'h63, JAL = 7'h6F, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, want);
    end
  endtask

  function automatic logic [19:0] V(input logic mr, input logic mw, input logic ad,
                                    input logic ir, input logic pc, input logic rw,
                                    input logic [1:0] rs, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [3:0] alu,
                                    input logic [2:0] imm, input logic ill);
    return {mr, mw, ad, ir, pc, rw, rs, sa, sb, alu, imm, ill};
  endfunction

  function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic f7, input logic rtype);
    case (f3)
      3'd0: return (rtype && f7) ? 4'h1 : 4'h0;
      3'd1: return 4'h7;
      3'd2: return 4'h5;
      3'd3: return 4'h6;
      3'd4: return 4'h4;
      3'd5: return f7 ? 4'h9 : 4'h8;
      3'd6: return 4'h3;
      default: return 4'h2;
    endcase
  endfunction

  function automatic logic exp_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return lu;
      default: return !lu;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    if (o == STORE) return 3'd1;
    if (o == BRANCH) return 3'd2;
    if (o == JAL) return 3'd3;
    if (o == LUI || o == AUIPC) return 3'd4;
    return 3'd0;
  endfunction

  // Entered at posedge+1; drives mem_ready, samples on the falling edge, ends at next posedge+1.
  task automatic cyc(input string tag, input logic rdy, input logic [19:0] want, input logic [19:0] mask);
    logic [19:0] m;
    m = mask | M_STB;
    mem_ready = rdy;
    @(negedge clk);
    check(tag, obs & m, want & m);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_fetch(input int waits);
    for (int w = 0; w < waits; w++)
      cyc("fetch_wait", 1'b0, V(1,0,0,0,0,0,2'b10,2'b00,2'b10,4'h0,3'd0,0), M_ADR|M_RS|M_SA|M_SB|M_ALU);
    cyc("fetch", 1'b1, V(1,0,0,1,1,0,2'b10,2'b00,2'b10,4'h0,3'd0,0), M_ADR|M_RS|M_SA|M_SB|M_ALU);
  endtask

  task automatic do_decode();
    logic [19:0] m;
    m = M_SA | M_SB | M_ALU;
    if (op != RTYPE) m = m | M_IMM;
    cyc("decode", rnd_bit(), V(0,0,0,0,0,0,2'b00,2'b01,2'b01,4'h0,exp_imm(op),0), m);
  endtask

  // Runs one instruction from FETCH back to FETCH (or into TRAP) using the class tables.
  task automatic run_instr(input int fw, input int mw);
    logic t;
    $display("instr op=%07b f3=%0d f7b5=%0d z/lt/ltu=%0d%0d%0d fetch_waits=%0d mem_waits=%0d",
             op, funct3, funct7b5, zero, lt, ltu, fw, mw);
    do_fetch(fw);
    do_decode();
    case (op)
      LOAD, STORE: begin
        cyc("memadr", rnd_bit(), V(0,0,0,0,0,0,2'b00,2'b10,2'b01,4'h0,exp_imm(op),0), M_SA|M_SB|M_ALU|M_IMM);
        for (int w = 0; w <= mw; w++)
          if (op == LOAD) cyc("memread", w == mw, V(1,0,1,0,0,0,0,0,0,0,0,0), M_ADR);
          else            cyc("memwrite", w == mw, V(1,1,1,0,0,0,0,0,0,0,0,0), M_ADR);
        if (op == LOAD) cyc("memwb", rnd_bit(), V(0,0,0,0,0,1,2'b01,0,0,0,0,0), M_RS);
      end
      RTYPE, ITYPE: begin
        cyc(op == RTYPE ? "execr" : "execi", rnd_bit(),
            V(0,0,0,0,0,0,0,2'b10,op == RTYPE ? 2'b00 : 2'b01,exp_alu(funct3, funct7b5, op == RTYPE),3'd0,0),
            M_SA|M_SB|M_ALU);
        cyc("aluwb", rnd_bit(), V(0,0,0,0,0,1,2'b00,0,0,0,0,0), M_RS);
      end
      BRANCH: begin
        if (funct3 == 3'd2 || funct3 == 3'd3) begin
          cyc("branch_bad", rnd_bit(), V(0,0,0,0,0,0,0,0,0,0,0,0), 20'h0);
        end else begin
          t = exp_taken(funct3, zero, lt, ltu);
          cyc("branch", rnd_bit(), V(0,0,0,0,t,0,2'b00,2'b10,2'b00,4'h1,3'd2,0), M_RS|M_SA|M_SB|M_ALU);
        end
      end
      JAL: begin
        cyc("jal", rnd_bit(), V(0,0,0,0,1,0,2'b00,2'b01,2'b10,4'h0,3'd3,0), M_RS|M_SA|M_SB|M_ALU);
        cyc("aluwb", rnd_bit(), V(0,0,0,0,0,1,2'b00,0,0,0,0,0), M_RS);
      end
      JALR: begin
        cyc("jalr", rnd_bit(), V(0,0,0,0,1,0,2'b10,2'b10,2'b01,4'h0,3'd0,0), M_RS|M_SA|M_SB|M_ALU|M_IMM);
        cyc("jalrwb", rnd_bit(), V(0,0,0,0,0,1,2'b10,2'b01,2'b10,4'h0,3'd0,0), M_RS|M_SA|M_SB|M_ALU);
      end
      LUI, AUIPC: begin
        cyc("upper", rnd_bit(), V(0,0,0,0,0,0,0,op == LUI ? 2'b11 : 2'b01,2'b01,4'h0,3'd4,0), M_SA|M_SB|M_ALU|M_IMM);
        cyc("aluwb", rnd_bit(), V(0,0,0,0,0,1,2'b00,0,0,0,0,0), M_RS);
      end
      default: ;
    endcase
  endtask

  task automatic check_trap_and_reset(input int cycles);
    for (int i = 0; i < cycles; i++)
      cyc("trap", rnd_bit(), V(0,0,0,0,0,0,0,0,0,0,0,1), 20'h0);
    reset_n = 1'b0;
    #1;
    check("trap_reset_clears", obs & M_STB, 20'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [6:0] ops [9] = '{LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR, LUI, AUIPC};
  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    reset_n = 1'b0; op = RTYPE; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", obs & M_STB, 20'h0);
    reset_n = 1'b1;

    // add, zero wait states
    op = RTYPE; funct3 = 3'd0; funct7b5 = 1'b0;
    run_instr(0, 0);
    // lw with two wait cycles in fetch and memread
    op = LOAD; funct3 = 3'd2;
    run_instr(2, 2);
    // bne not taken, then taken
    op = BRANCH; funct3 = 3'd1; zero = 1'b1;
    run_instr(0, 0);
    zero = 1'b0;
    run_instr(1, 0);
    // jalr
    op = JALR; funct3 = 3'd0;
    run_instr(0, 0);
    // sub and srai exercise the funct7b5 paths
    op = RTYPE; funct3 = 3'd0; funct7b5 = 1'b1;
    run_instr(0, 0);
    op = ITYPE; funct3 = 3'd0;
    run_instr(0, 0);
    op = ITYPE; funct3 = 3'd5;
    run_instr(0, 0);

    // undecodable opcode, then reset recovery
    op = 7'b1111111;
    run_instr(0, 0);
    check_trap_and_reset(10);
    // branch with reserved funct3 also traps
    op = BRANCH; funct3 = 3'd2;
    run_instr(0, 0);
    check_trap_and_reset(3);

    // reset during a stalled store
    op = STORE; funct3 = 3'd2;
    do_fetch(0);
    do_decode();
    cyc("memadr", 1'b0, V(0,0,0,0,0,0,2'b00,2'b10,2'b01,4'h0,3'd1,0), M_SA|M_SB|M_ALU|M_IMM);
    cyc("memwrite_stall", 1'b0, V(1,1,1,0,0,0,0,0,0,0,0,0), M_ADR);
    mem_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    check("memwrite_abort", obs & M_STB, 20'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    op = LUI;
    run_instr(0, 0);

    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 8)];
      funct3 = (op == BRANCH) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      funct7b5 = rnd_bit();
      zero = rnd_bit(); lt = rnd_bit(); ltu = rnd_bit();
      run_instr($urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_mc_controller.md
# rv_mc_controller

Multi-cycle control FSM for the RV32I core variant that shares one ALU and one unified memory port across fetch, address generation and execute. Decodes the latched instruction fields, sequences each instruction through 3-5 states and drives every datapath select and write strobe. Drives `immsrc` for the immediate extender, using the extender's existing encoding. Memory accesses are stalled through a ready handshake.

## Interface
Parameters: none.
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `op`  in  7  instr[6:0] from instruction register
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `zero`, `lt`, `ltu`  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request valid
- `memwrite`  out  1  request is a store
- `adrsrc`  out  1  0 = PC, 1 = ALUOut
- `irwrite`  out  1  latch instruction and oldPC
- `pcwrite`  out  1  PC <- Result
- `regwrite`  out  1  register file write
- `resultsrc`  out  2  00 ALUOut, 01 read data, 10 ALUResult
- `alusrca`  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero
- `alusrcb`  out  2  00 rs2, 01 immext, 10 constant 4
- `immsrc`  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- `alucontrol`  out  4  ALU operation code
- `illegal`  out  1  sticky, undecodable opcode seen

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRWB, UPPER, TRAP.
- FETCH: `mem_req`=1, `adrsrc`=0, PC+4 on ALU (00/10/add), `resultsrc`=10. On `mem_ready`: `irwrite`=1, `pcwrite`=1, go to DECODE. Otherwise hold.
- DECODE: ALU = oldPC+imm with `immsrc` from `op`. Dispatch by `op`: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111/0010111 -> UPPER; anything else -> TRAP.
- MEMADR: rs1+imm (I for loads, S for stores). Next state is MEMREAD if `op[5]`=0, else MEMWRITE.
- MEMREAD: `mem_req`=1, `adrsrc`=1. On `mem_ready`, go to MEMWB. MEMWB: `resultsrc`=01, `regwrite`=1, then FETCH.
- MEMWRITE: `mem_req`=1, `memwrite`=1, `adrsrc`=1. On `mem_ready`, go to FETCH.
- EXECR: rs1 op rs2. EXECI: rs1 op imm(I). Both go to ALUWB. ALUWB: `resultsrc`=00, `regwrite`=1, then FETCH.
- BRANCH: rs1 vs rs2 with `alucontrol`=SUB and `resultsrc`=00 (the target from DECODE).
  - `pcwrite` = taken, where funct3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 -> TRAP.
  - Next state FETCH.
- JAL: `pcwrite`=1 with `resultsrc`=00, ALU = oldPC+4, then ALUWB.
- JALR: ALU = rs1+imm(I), `resultsrc`=10, `pcwrite`=1, then JALRWB. JALRWB: oldPC+4, `resultsrc`=10, `regwrite`=1, then FETCH.
- UPPER: `alusrca`=11 if `op[5]` (LUI) else 01 (AUIPC); imm(U), add; then ALUWB.
- ALU decode (`aluop`: add / branch-sub / funct), per funct3:
  - 000: ADD, or SUB when R-type and `funct7b5`.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL, or SRA when `funct7b5`. 110: OR. 111: AND.
- TRAP: all strobes 0, `illegal`=1, state held until reset.

## Timing
- Reset (async assert, sync release): state FETCH, `illegal`=0. While `reset_n`=0, all strobes and `mem_req` are 0. First `mem_req` appears the cycle after release.
- Outputs are Moore decodes of state. Exceptions: `irwrite`/`pcwrite` in FETCH are gated by `mem_ready`; `pcwrite` in BRANCH is gated by the flags.
- Zero-wait-state cycles per instruction: R, I-ALU, LUI, AUIPC, JAL, JALR, store: 4. Load: 5. Branch: 3. Each wait cycle adds 1.
- `mem_req` stays high and the address select stays stable until `mem_ready`. `mem_ready` outside a requesting state is ignored.
- Reset asserted mid-instruction aborts it immediately. No partial write strobe is issued.

## Structure
- Package `rv_mc_pkg`: state enum, `alucontrol` codes (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001), `immsrc` codes, opcode constants.
- One sub-module, `rv_mc_aludec`: combinational (aluop, funct3, funct7b5, op[5]) -> alucontrol.

## Test plan
- `add` (op 0110011, funct3 000, f7b5 0), `mem_ready` always 1 -> states FETCH, DECODE, EXECR, ALUWB; `alucontrol`=0000; `regwrite` high only in cycle 4.
- `lw` with `mem_ready` low for 2 cycles in both FETCH and MEMREAD -> 9 cycles total; `mem_req` held; `irwrite` pulses exactly once.
- `bne` with `zero`=1 -> `pcwrite` 0 in BRANCH. With `zero`=0 -> `pcwrite` 1. `immsrc`=010 in DECODE.
- `jalr` -> JALR `pcwrite`=1, `resultsrc`=10; JALRWB `alusrca`=01, `alusrcb`=10, `regwrite`=1.
- op 1111111 -> TRAP, `illegal`=1, `mem_req` stays 0 for 10 cycles. Pulsing `reset_n` low clears `illegal` and restarts FETCH.
- `reset_n` pulled low during MEMWRITE -> `memwrite` and `mem_req` drop the same cycle; after release, state is FETCH.
